// File: rtl/bldc_pkg.sv
// Shared encodings and lookup tables for the six-step BLDC commutator.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package bldc_pkg;

    // Commanded mode encodings
    localparam logic [1:0] MODE_COAST = 2'b00;
    localparam logic [1:0] MODE_CW    = 2'b01;
    localparam logic [1:0] MODE_CCW   = 2'b10;
    localparam logic [1:0] MODE_BRAKE = 2'b11;

    // Per-leg request; LEG_OFF doubles as "none" for the last-driven side
    typedef enum logic [1:0] {
        LEG_OFF = 2'b00,
        LEG_HI  = 2'b01,
        LEG_LO  = 2'b10
    } leg_req_e;

    localparam logic [2:0] STEP_INVALID = 3'd7;

    // Bit positions inside pt = {AH,AL,BH,BL,CH,CL}
    localparam int PT_AH = 5;
    localparam int PT_AL = 4;
    localparam int PT_BH = 3;
    localparam int PT_BL = 2;
    localparam int PT_CH = 1;
    localparam int PT_CL = 0;

    // Filtered hall code {H2,H1,H0} -> step; 000 and 111 are illegal
    localparam logic [7:0][2:0] HALL_STEP = {
        3'd7,   // 111
        3'd2,   // 110
        3'd0,   // 101
        3'd1,   // 100
        3'd4,   // 011
        3'd3,   // 010
        3'd5,   // 001
        3'd7    // 000
    };

    // CW step -> {A,B,C} leg requests, two bits per leg (HI=01, LO=10).
    // Entries 6 and 7 request all legs off so an invalid step is harmless.
    localparam logic [7:0][5:0] STEP_DRIVE = {
        6'b000000,  // 7
        6'b000000,  // 6
        6'b001001,  // 5: C hi, B lo
        6'b100001,  // 4: C hi, A lo
        6'b100100,  // 3: B hi, A lo
        6'b000110,  // 2: B hi, C lo
        6'b010010,  // 1: A hi, C lo
        6'b011000   // 0: A hi, B lo
    };

    localparam logic [5:0] BRAKE_DRIVE = 6'b101010;

    // True when two valid steps are neighbours on the six-step ring
    function automatic logic steps_adjacent(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] a_next;
        logic [2:0] b_next;
        a_next = (a == 3'd5) ? 3'd0 : a + 3'd1;
        b_next = (b == 3'd5) ? 3'd0 : b + 3'd1;
        return (a_next == b) || (b_next == a);
    endfunction

endpackage

// File: rtl/bldc_commutator_dt_leg.sv
// One half-bridge: OFF/HI/LO FSM with dead-time counter between opposite sides.
// Latency: 1 cycle request->gate when no dead time is owed; turn-off is always 1 cycle.
// Backpressure: none; a request to the opposite side simply waits in OFF until dead time expires.
module bldc_leg_dt
    import bldc_pkg::*;
#(
    parameter int DEADTIME_CYC = 4,
    parameter int DT_W         = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  leg_req_e req_i,
    output logic     hi_o,
    output logic     lo_o
);

    localparam logic [DT_W-1:0] DT_MAX = DT_W'(DEADTIME_CYC);

    leg_req_e        state_q;
    leg_req_e        last_q;
    logic [DT_W-1:0] cnt_q;
    logic            hi_q;
    logic            lo_q;
    logic            dt_done;

    // cnt_q counts off cycles already completed; the cycle ending at this edge
    // is one more, so the opposite side may rise exactly DEADTIME_CYC cycles
    // after the other side fell.
    assign dt_done = ({1'b0, cnt_q} + {{DT_W{1'b0}}, 1'b1}) >= {1'b0, DT_MAX};

    // Leg FSM with registered gate outputs; leaving HI or LO always passes through OFF
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LEG_OFF;
            last_q  <= LEG_OFF;
            cnt_q   <= DT_MAX;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            case (state_q)
                LEG_HI, LEG_LO: begin
                    if (req_i != state_q) begin
                        state_q <= LEG_OFF;
                        cnt_q   <= '0;
                        hi_q    <= 1'b0;
                        lo_q    <= 1'b0;
                    end
                end
                default: begin
                    if (cnt_q != DT_MAX) begin
                        cnt_q <= cnt_q + DT_W'(1);
                    end
                    if ((req_i != LEG_OFF) && ((req_i == last_q) || dt_done)) begin
                        state_q <= req_i;
                        last_q  <= req_i;
                        hi_q    <= (req_i == LEG_HI);
                        lo_q    <= (req_i == LEG_LO);
                    end
                end
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/bldc_commutator_dt.sv
// Six-step sensored BLDC commutator: hall sync/filter, step decode, fault, per-leg dead time.
// Latency: hall edge -> step 2+HALL_FILT cycles; step -> pt 1 cycle (plus dead time if owed).
// Backpressure: none; optional HALL_SEQ_CHECK_EN adds a non-adjacent-step fault check.
module bldc_commutator_dt
    import bldc_pkg::*;
#(
    parameter int DEADTIME_CYC = 4,
    parameter int HALL_FILT    = 3,
    parameter int DT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall,
    input  logic [1:0] mode,
    input  logic       pwm_in,
    input  logic       fault_clr,
    output logic [5:0] pt,
    output logic [2:0] step,
    output logic       hall_fault
);

    localparam logic [3:0] FILT_N = 4'(HALL_FILT);

    logic [2:0] sync1_q, sync2_q;
    logic [2:0] filt_q, filt_d;
    logic [2:0] cand_q, cand_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic       filt_vld_q, filt_vld_d;
    logic [2:0] step_q, step_d;
    logic       fault_q, fault_d;
    logic       run_mode;
    logic       seq_err;
    logic       fault_set;
    logic [2:0] ccw_step;
    logic [5:0] drive;
    leg_req_e   leg_req [3];
    logic [2:0] leg_hi, leg_lo;

    assign run_mode = (mode == MODE_CW) || (mode == MODE_CCW);

    // Filter: accept a code after HALL_FILT identical samples that differ from the
    // current one. Until the first code is accepted, even 000 counts as "new", so a
    // stuck 000/111 hall is still reported after reset.
    always_comb begin
        filt_d     = filt_q;
        cand_d     = cand_q;
        fcnt_d     = fcnt_q;
        filt_vld_d = filt_vld_q;
        if (filt_vld_q && (sync2_q == filt_q)) begin
            fcnt_d = '0;
        end else if ((fcnt_q != 4'd0) && (sync2_q == cand_q)) begin
            if ((fcnt_q + 4'd1) >= FILT_N) begin
                filt_d     = sync2_q;
                filt_vld_d = 1'b1;
                fcnt_d     = '0;
            end else begin
                fcnt_d = fcnt_q + 4'd1;
            end
        end else begin
            cand_d = sync2_q;
            if (FILT_N <= 4'd1) begin
                filt_d     = sync2_q;
                filt_vld_d = 1'b1;
                fcnt_d     = '0;
            end else begin
                fcnt_d = 4'd1;
            end
        end
        step_d = filt_vld_d ? HALL_STEP[filt_d] : STEP_INVALID;
    end

    // Hall synchroniser, filter state and registered step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            cand_q     <= '0;
            fcnt_q     <= '0;
            filt_vld_q <= 1'b0;
            step_q     <= STEP_INVALID;
        end else begin
            sync1_q    <= hall;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            cand_q     <= cand_d;
            fcnt_q     <= fcnt_d;
            filt_vld_q <= filt_vld_d;
            step_q     <= step_d;
        end
    end

`ifdef HALL_SEQ_CHECK_EN
    logic [2:0] prev_step_q;

    // Previous step, used to spot hall jumps that skip positions on the ring
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_step_q <= STEP_INVALID;
        end else begin
            prev_step_q <= step_q;
        end
    end

    assign seq_err = run_mode && (step_q != STEP_INVALID) && (prev_step_q != STEP_INVALID)
                     && (step_q != prev_step_q) && !steps_adjacent(step_q, prev_step_q);
`else
    assign seq_err = 1'b0;
`endif

    // Only an accepted illegal code counts; the pre-filter unknown state does not
    assign fault_set = (run_mode && filt_vld_q && (step_q == STEP_INVALID)) || seq_err;

    // Sticky fault: set beats clear, and clear is ignored while the step is invalid
    always_comb begin
        fault_d = fault_q;
        if (fault_set) begin
            fault_d = 1'b1;
        end else if (fault_clr && (step_q != STEP_INVALID)) begin
            fault_d = 1'b0;
        end
    end

    // Registered hall fault flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    // Leg requests from step/mode/fault, with the high sides gated by PWM
    always_comb begin
        if (step_q < 3'd3) begin
            ccw_step = step_q + 3'd3;
        end else if (step_q < 3'd6) begin
            ccw_step = step_q - 3'd3;
        end else begin
            ccw_step = STEP_INVALID;
        end
        drive = 6'b000000;
        if (!fault_q) begin
            case (mode)
                MODE_CW:    drive = STEP_DRIVE[step_q];
                MODE_CCW:   drive = STEP_DRIVE[ccw_step];
                MODE_BRAKE: drive = BRAKE_DRIVE;
                default:    drive = 6'b000000;
            endcase
        end
        for (int i = 0; i < 3; i++) begin
            leg_req[i] = leg_req_e'(drive[4-2*i +: 2]);
            if ((leg_req[i] == LEG_HI) && !pwm_in) begin
                leg_req[i] = LEG_OFF;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_leg
        bldc_leg_dt #(
            .DEADTIME_CYC(DEADTIME_CYC),
            .DT_W        (DT_W)
        ) u_leg (
            .clk  (clk),
            .rst  (rst),
            .req_i(leg_req[g]),
            .hi_o (leg_hi[g]),
            .lo_o (leg_lo[g])
        );
    end

    // Gate bus assembly; leg index 0/1/2 is phase A/B/C
    always_comb begin
        pt        = 6'b000000;
        pt[PT_AH] = leg_hi[0];
        pt[PT_AL] = leg_lo[0];
        pt[PT_BH] = leg_hi[1];
        pt[PT_BL] = leg_lo[1];
        pt[PT_CH] = leg_hi[2];
        pt[PT_CL] = leg_lo[2];
    end

    assign step       = step_q;
    assign hall_fault = fault_q;

endmodule

// File: doc/bldc_commutator_dt.md
Name: bldc_commutator_dt

Overview:
Parametrised six-step commutation controller for a sensored BLDC motor. It filters the three hall inputs and decodes them to a commutation step. From the step and the commanded mode (coast / CW / CCW / brake) it drives the six power-transistor gates. Each half-bridge gets programmable dead time and high-side PWM gating. The block sits between the UART command decoder and the gate-driver pins, and replaces the fixed two-cycle-delay commutation logic.

Parameters:
DEADTIME_CYC, 4, minimum clk cycles both gates of a leg are off before the opposite side turns on (1..255)
HALL_FILT, 3, consecutive identical synchronised hall samples required to accept a new code (1..15)
DT_W, 8, width of the dead-time counter; must hold DEADTIME_CYC

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
hall  in  3  raw hall sensors {H2,H1,H0}, asynchronous to clk
mode  in  2  00 coast, 01 CW, 10 CCW, 11 regen brake
pwm_in  in  1  high-side PWM gate enable (1 = on)
fault_clr  in  1  single-cycle pulse; clears sticky hall fault
pt  out  6  gate drives {AH,AL,BH,BL,CH,CL}, 1 = on
step  out  3  decoded step 0..5; 7 = invalid/unknown
hall_fault  out  1  sticky illegal-hall flag

Behaviour:
- Reset: pt=0, step=7, hall_fault=0. Sync flops and filtered hall = 3'b000. Filter count = 0. Every leg is in OFF with dead-time count saturated and "last side" = none.
- Reset may assert at any time. pt goes to 0 asynchronously, within the same cycle.
- Hall path: 2-flop synchroniser. Filter accepts the new code after HALL_FILT consecutive equal samples that differ from the current filtered code. Any mismatch restarts the count.
- Step decode (filtered {H2,H1,H0}): 101→0, 100→1, 110→2, 010→3, 011→4, 001→5, 000/111→7.
- Drive table, CW, per step (high-side, low-side):
  - 0: A, B
  - 1: A, C
  - 2: B, C
  - 3: B, A
  - 4: C, A
  - 5: C, B
  - The third leg is OFF.
- CCW uses the entry for (step+3) mod 6.
- Coast: all legs OFF.
- Brake: all legs LO, independent of hall.
- Fault handling:
  - step=7 with mode CW or CCW sets hall_fault.
  - While hall_fault=1, all legs are requested OFF regardless of mode, including brake.
  - fault_clr clears hall_fault only if step≠7 in that cycle; otherwise the pulse is ignored.
  - A simultaneous set condition and clear: set wins.
- PWM: a leg requested HI with pwm_in=0 is treated as request OFF. Low sides are not complemented. pwm_in is used directly and must be synchronous to clk.
- Per-leg dead-time FSM, states OFF, HI, LO:
  - Any state → OFF: immediate. The counter clears to 0 and counts up, saturating at DEADTIME_CYC.
  - OFF → same side as last driven: immediate.
  - OFF → opposite side (or last=none after reset): only when count ≥ DEADTIME_CYC. Reset initialises count saturated.
  - HI ↔ LO direct request: go to OFF first, then follow the rule above.
  - Invariant: xH and xL are never both 1. Between xH falling and xL rising there are at least DEADTIME_CYC cycles, and vice versa.
- pt and step are registered. hall edge → step update = 2+HALL_FILT cycles. step update → pt change = 1 cycle if no dead time is required.

Optional Feature:
HALL_SEQ_CHECK_EN.
- Defined: while mode is CW or CCW, a filtered step change that is not ±1 mod 6 (e.g. 0→3) sets hall_fault, with the same sticky/clear rules. Changes to or from 7 are excluded because they are already covered by the step=7 rule.
- Undefined: only codes 000/111 set the fault; no previous-step register is synthesised.

Decomposition:
- Package bldc_pkg holds:
  - mode encodings (MODE_COAST/CW/CCW/BRAKE)
  - leg request enum (LEG_OFF, LEG_HI, LEG_LO)
  - hall→step table and step→leg-request table constants
  - STEP_INVALID = 3'd7
  - pt bit index constants
- One sub-module, bldc_leg_dt, contains the per-leg dead-time FSM plus counter, parametrised by DEADTIME_CYC and DT_W. It is instantiated three times.

Test Plan:
- Reset while mode=01, hall=101 → pt=0 asynchronously. After release, step=0 at cycle 5 (2+3) and pt=6'b100100 (AH,BL) at cycle 6.
- CW, pwm_in=1, hall 101→100 → step=1, pt becomes 6'b100001. Leg B goes OFF; B's low side was last, so no AH/CL dead-time delay applies.
- CW step 0 then mode→CCW (uses step 3: B high, A low) → AH drops immediately, AL rises exactly 4 cycles later. BL drops, BH rises 4 cycles later. There is never an overlap on any leg.
- Hall glitch 101→100 for 2 cycles then back → step stays 0 and pt unchanged.
- CW with hall=111 → hall_fault=1, pt=0. fault_clr while 111 → still 1. Hall→101, then fault_clr → hall_fault=0 and pt resumes 6'b100100.
- Brake, pwm_in toggling → pt=6'b010101 throughout. With HALL_SEQ_CHECK_EN in CW, hall 101→010 (step 0→3) → hall_fault=1.
